mm_exp_ctrl: RTL and testbench

Modular exponentiation sequencer for the RSA datapath: computes result = msg^exp mod n by issuing a sequence of Montgomery multiplications to an external MM core. It is the initiator on the MM en/module_end interface. It drives the operands and en, then consumes Z on module_end. It implements left-to-right binary exponentiation entirely in the Montgomery domain (R = 2^WIDTH).

---
 rtl/mm_exp_ctrl_if.sv | 22 ++
 rtl/mm_exp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mm_exp_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_exp_ctrl_if.sv
// Montgomery-multiplier request/response bus between the exponentiation
// sequencer (master) and the MM core (slave).
interface mm_exp_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             mm_en;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_n;
  logic [WIDTH-1:0] mm_z;
  logic             mm_done;

  modport master (
    output mm_en, mm_a, mm_b, mm_n,
    input  mm_z, mm_done
  );

  modport slave (
    input  mm_en, mm_a, mm_b, mm_n,
    output mm_z, mm_done
  );
endinterface

// File: rtl/mm_exp_ctrl.sv
// Left-to-right binary modular exponentiation in the Montgomery domain.
// Optional LEADING_ZERO_SKIP_EN: SCAN skips leading zero exponent bits.
module mm_exp_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  mm_exp_ctrl_if.master    mm
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CX   = 4'd1;
  localparam logic [3:0] S_CA   = 4'd2;
  localparam logic [3:0] S_SCAN = 4'd3;
  localparam logic [3:0] S_SQR  = 4'd4;
  localparam logic [3:0] S_MUL  = 4'd5;
  localparam logic [3:0] S_NEXT = 4'd6;
  localparam logic [3:0] S_OUT  = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DEC = CNT_W'(1);

  logic [3:0]       state;
  logic [3:0]       tgt;
  logic [3:0]       scan_nxt;
  logic [WIDTH-1:0] msg_r;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] r2_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] xm;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] idx;
  logic             cur_bit;
  logic             tgt_mm;
  logic             load;
  logic             hit;

  assign cur_bit = exp_r[idx[IW-1:0]];
  assign hit     = mm.mm_en & mm.mm_done;

`ifdef LEADING_ZERO_SKIP_EN
  // Walk down past leading zeros; an all-zero exponent needs only the exit conversion.
  always_comb begin
    if (exp_r == '0)
      scan_nxt = S_OUT;
    else if (!cur_bit && idx != '0)
      scan_nxt = S_SCAN;
    else
      scan_nxt = S_SQR;
  end
`else
  assign scan_nxt = S_SQR;
`endif

  // SCAN and NEXT issue on behalf of the following MM state so the en gap stays one cycle.
  always_comb begin
    tgt = state;
    if (state == S_SCAN)
      tgt = scan_nxt;
    else if (state == S_NEXT)
      tgt = (idx == '0) ? S_OUT : S_SQR;
  end

  // Operand selection for the MM operation about to be issued.
  always_comb begin
    op_a   = acc;
    op_b   = acc;
    tgt_mm = 1'b1;
    case (tgt)
      S_CX: begin
        op_a = msg_r;
        op_b = r2_r;
      end
      S_CA: begin
        op_a = ONE;
        op_b = r2_r;
      end
      S_SQR: op_b = acc;
      S_MUL: op_b = xm;
      S_OUT: op_b = ONE;
      default: tgt_mm = 1'b0;
    endcase
  end

  assign load = tgt_mm & ~mm.mm_en;

  // Sequencer: MM request/capture handshake and exponent bit walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mm.mm_en <= 1'b0;
      mm.mm_a  <= '0;
      mm.mm_b  <= '0;
      mm.mm_n  <= '0;
      msg_r    <= '0;
      exp_r    <= '0;
      n_r      <= '0;
      r2_r     <= '0;
      acc      <= '0;
      xm       <= '0;
      idx      <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mm.mm_a  <= op_a;
        mm.mm_b  <= op_b;
        mm.mm_n  <= n_r;
        mm.mm_en <= 1'b1;
      end else if (hit) begin
        mm.mm_en <= 1'b0;
      end
      case (state)
        S_IDLE: if (start) begin
          msg_r <= msg;
          exp_r <= exp;
          n_r   <= n;
          r2_r  <= r2;
          busy  <= 1'b1;
          state <= S_CX;
        end
        S_CX: if (hit) begin
          xm    <= mm.mm_z;
          state <= S_CA;
        end
        S_CA: if (hit) begin
          acc   <= mm.mm_z;
          idx   <= TOP;
          state <= S_SCAN;
        end
        S_SCAN: begin
          state <= scan_nxt;
          if (scan_nxt == S_SCAN)
            idx <= idx - DEC;
        end
        S_SQR: if (hit) begin
          acc   <= mm.mm_z;
          state <= cur_bit ? S_MUL : S_NEXT;
        end
        S_MUL: if (hit) begin
          acc   <= mm.mm_z;
          state <= S_NEXT;
        end
        S_NEXT: begin
          state <= tgt;
          if (idx != '0)
            idx <= idx - DEC;
        end
        S_OUT: if (hit) begin
          result <= mm.mm_z;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_exp_ctrl.sv
// Directed bench for mm_exp_ctrl with a Montgomery MM core model.
// Build with +define+LEADING_ZERO_SKIP_EN to check the skip variant.
module tb_mm_exp_ctrl;

  localparam int W = 32;
`ifdef LEADING_ZERO_SKIP_EN
  localparam int OPS_E3 = 7;
  localparam int OPS_E1 = 5;
  localparam int OPS_E0 = 3;
`else
  localparam int OPS_E3 = 37;
  localparam int OPS_E1 = 36;
  localparam int OPS_E0 = 35;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] msg = '0;
  logic [W-1:0] exp = '0;
  logic [W-1:0] n = 32'd77;
  logic [W-1:0] r2 = 32'd16;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  mm_exp_ctrl_if #(.WIDTH(W)) mm();

  mm_exp_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .msg(msg),
    .exp(exp),
    .n(n),
    .r2(r2),
    .busy(busy),
    .done(done),
    .result(result),
    .mm(mm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int pass = 0;
  int fail = 0;

  int lat = 3;
  int cnt;
  logic clr = 1'b0;
  logic prev_en;
  logic seen;
  int rises, dones, stab_err, low_run, gmin, gmax;
  logic [W-1:0] sa, sb, sn;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
    logic [2*W+1:0] t;
    t = (2*W+2)'(a) * (2*W+2)'(b);
    for (int i = 0; i < W; i++) begin
      if (t[0])
        t = t + (2*W+2)'(m);
      t = t >> 1;
    end
    if (t >= (2*W+2)'(m))
      t = t - (2*W+2)'(m);
    return t[W-1:0];
  endfunction

  // MM core model: answers lat cycles after it sees en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm.mm_done <= 1'b0;
      mm.mm_z    <= '0;
      cnt        <= 0;
    end else if (mm.mm_en && !mm.mm_done) begin
      if (cnt >= lat - 1) begin
        mm.mm_z    <= mont(mm.mm_a, mm.mm_b, mm.mm_n);
        mm.mm_done <= 1'b1;
        cnt        <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      mm.mm_done <= 1'b0;
      cnt        <= 0;
    end
  end

  // Bus monitor: request count, operand stability, en gaps, done pulses.
  always @(negedge clk) begin
    prev_en <= mm.mm_en;
    if (clr) begin
      rises    <= 0;
      dones    <= 0;
      stab_err <= 0;
      low_run  <= 0;
      gmin     <= 1000;
      gmax     <= 0;
      seen     <= 1'b0;
    end else begin
      if (mm.mm_en && !prev_en) begin
        rises <= rises + 1;
        sa    <= mm.mm_a;
        sb    <= mm.mm_b;
        sn    <= mm.mm_n;
        if (seen) begin
          if (low_run < gmin) gmin <= low_run;
          if (low_run > gmax) gmax <= low_run;
        end
        seen    <= 1'b1;
        low_run <= 0;
      end else if (mm.mm_en) begin
        if (mm.mm_a !== sa || mm.mm_b !== sb || mm.mm_n !== sn)
          stab_err <= stab_err + 1;
      end else if (busy) begin
        low_run <= low_run + 1;
      end
      if (done)
        dones <= dones + 1;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
    total++;
    assert (obs === req) pass++;
    else begin
      fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] m, input logic [W-1:0] e, input int l,
                     input bit hammer, output bit ok, output bit b1);
    clear_mon();
    lat   = l;
    msg   = m;
    exp   = e;
    n     = 32'd77;
    r2    = 32'd16;
    start = 1'b1;
    @(negedge clk);
    b1 = busy;
    if (hammer) begin
      msg = 32'd2;
      exp = 32'd5;
      r2  = 32'd9;
    end else begin
      start = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit ok;
    bit b1;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", result, 0);
    check("rst_en", 32'(mm.mm_en), 0);
    check("rst_a", mm.mm_a, 0);
    check("rst_b", mm.mm_b, 0);
    check("rst_n", mm.mm_n, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(32'd5, 32'd3, 40, 1'b0, ok, b1);
    check("e3_finish", 32'(ok), 1);
    check("e3_busy", 32'(b1), 1);
    check("e3_result", result, 48);
    check("e3_dones", 32'(dones), 1);
    check("e3_ops", 32'(rises), 32'(OPS_E3));
    check("e3_stable", 32'(stab_err), 0);
    check("e3_gap_min", 32'(gmin), 1);
`ifndef LEADING_ZERO_SKIP_EN
    check("e3_gap_max", 32'(gmax), 1);
`endif
    check("e3_idle", 32'(busy), 0);

    run(32'd76, 32'd1, 3, 1'b0, ok, b1);
    check("e1_finish", 32'(ok), 1);
    check("e1_result", result, 76);
    check("e1_ops", 32'(rises), 32'(OPS_E1));

    run(32'd5, 32'd0, 3, 1'b0, ok, b1);
    check("e0_finish", 32'(ok), 1);
    check("e0_result", result, 1);
    check("e0_ops", 32'(rises), 32'(OPS_E0));

    run(32'd5, 32'd3, 3, 1'b1, ok, b1);
    check("ham_finish", 32'(ok), 1);
    check("ham_result", result, 48);
    check("ham_dones", 32'(dones), 1);
    check("ham_ops", 32'(rises), 32'(OPS_E3));

    clear_mon();
    lat   = 3;
    msg   = 32'd5;
    exp   = 32'd3;
    n     = 32'd77;
    r2    = 32'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && rises < 3; c++)
      @(negedge clk);
    check("ar_reach", 32'(rises >= 3), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_en", 32'(mm.mm_en), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("ar_no_done", 32'(dones), 0);
    check("ar_idle", 32'(busy), 0);

    run(32'd5, 32'd3, 3, 1'b0, ok, b1);
    check("re_finish", 32'(ok), 1);
    check("re_result", result, 48);
    check("re_dones", 32'(dones), 1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
